cmd_sequencer: RTL and testbench

Command sequencer that owns the PID heading/speed controller. Accepts one move command at a time (absolute heading plus a number of squares to travel), and drives the PID's `dsrd_hdng`, `moving` and `frwrd_spd` inputs. It first turns in place until the PID reports `at_hdng`, then ramps forward speed up, counts square-crossing pulses, and ramps back down to a stop. It sits between the command interface and the PID block in the motion datapath.

---
 rtl/cmd_seq_pkg.sv | 19 +
 rtl/cmd_sequencer_spd_ramp.sv | 66 ++++++
 rtl/cmd_sequencer.sv | 140 ++++++++++++++
 tb/tb_cmd_sequencer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_seq_pkg.sv
// Shared types and default tuning constants for the command sequencer.
package cmd_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TURN      = 3'd1,
    S_RAMP_UP   = 3'd2,
    S_CRUISE    = 3'd3,
    S_RAMP_DOWN = 3'd4,
    S_DONE      = 3'd5
  } seq_state_t;

  localparam logic [10:0] MAX_SPD_DEF  = 11'h2A0;
  localparam logic [10:0] ACCEL_DEF    = 11'd16;
  localparam logic [10:0] DECEL_DEF    = 11'd32;
  localparam int          RAMP_DIV_DEF = 8;
  localparam int          SETTLE_DEF   = 4;

endpackage

// File: rtl/cmd_sequencer_spd_ramp.sv
// Forward-speed register with a tick divider and saturating ramp up/down.
// The divider restarts whenever a ramp direction is newly requested, so the
// first speed step always lands RAMP_DIV cycles after entering a ramp.
module spd_ramp
  import cmd_seq_pkg::*;
#(
  parameter logic [10:0] MAX_SPD  = MAX_SPD_DEF,
  parameter logic [10:0] ACCEL    = ACCEL_DEF,
  parameter logic [10:0] DECEL    = DECEL_DEF,
  parameter int          RAMP_DIV = RAMP_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up,
  input  logic        down,
  input  logic        clr,
  output logic [10:0] spd,
  output logic        at_max,
  output logic        at_zero
);

  localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [DW-1:0] r_div;
  logic          r_was_up;
  logic          r_was_dn;
  logic [10:0]   r_spd;

  logic          w_enter;
  logic          w_tick;
  logic [11:0]   w_sum;
  logic [11:0]   w_diff;
  logic [10:0]   w_up_spd;
  logic [10:0]   w_dn_spd;

  assign w_enter  = (up && !r_was_up) || (down && !r_was_dn);
  assign w_tick   = (up || down) && !w_enter && (r_div == DW'(RAMP_DIV - 1));
  assign w_sum    = {1'b0, r_spd} + {1'b0, ACCEL};
  assign w_diff   = {1'b0, r_spd} - {1'b0, DECEL};
  // Borrow out of the 12-bit subtraction means the step would cross zero.
  assign w_up_spd = (w_sum > {1'b0, MAX_SPD}) ? MAX_SPD : w_sum[10:0];
  assign w_dn_spd = w_diff[11] ? 11'd0 : w_diff[10:0];

  // Divider, direction history and speed register.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_div    <= '0;
      r_was_up <= 1'b0;
      r_was_dn <= 1'b0;
      r_spd    <= '0;
    end else begin
      r_was_up <= up;
      r_was_dn <= down;
      if (!(up || down))  r_div <= '0;
      else if (w_enter)   r_div <= DW'(1);
      else if (w_tick)    r_div <= '0;
      else                r_div <= r_div + DW'(1);
      if (w_tick) r_spd <= up ? w_up_spd : w_dn_spd;
    end
  end

  assign spd     = r_spd;
  assign at_max  = (r_spd == MAX_SPD);
  assign at_zero = (r_spd == 11'd0);

endmodule

// File: rtl/cmd_sequencer.sv
// Move-command sequencer: turn to heading, ramp up, count squares, ramp down.
// All outputs to the PID and the command side are registered.
module cmd_sequencer
  import cmd_seq_pkg::*;
#(
  parameter logic [10:0] MAX_SPD  = MAX_SPD_DEF,
  parameter logic [10:0] ACCEL    = ACCEL_DEF,
  parameter logic [10:0] DECEL    = DECEL_DEF,
  parameter int          RAMP_DIV = RAMP_DIV_DEF,
  parameter int          SETTLE   = SETTLE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_vld,
  input  logic signed [11:0] cmd_hdng,
  input  logic        [2:0]  cmd_sqrs,
  output logic               cmd_rdy,
  input  logic               at_hdng,
  input  logic               sqr_pulse,
  input  logic               abort,
  output logic signed [11:0] dsrd_hdng,
  output logic               moving,
  output logic        [10:0] frwrd_spd,
  output logic               done
);

  localparam int SW = $clog2(SETTLE + 1);

  seq_state_t         r_state;
  seq_state_t         w_next;
  logic [SW-1:0]      r_settle;
  logic [2:0]         r_sqr_cnt;
  logic [2:0]         r_target;
  logic signed [11:0] r_hdng;
  logic               r_cmd_rdy;
  logic               r_moving;
  logic               r_done;

  logic               w_accept;
  logic               w_settled;
  logic [2:0]         w_cnt_nxt;
  logic               w_hit;
  logic               w_at_max;
  logic               w_at_zero;
  logic               w_cmd_rdy;
  logic               w_moving;
  logic               w_done;

  assign w_accept  = (r_state == S_IDLE) && cmd_vld && !abort;
  assign w_settled = at_hdng && (r_settle == SW'(SETTLE - 1));
  assign w_cnt_nxt = r_sqr_cnt + {2'b00, sqr_pulse};
  assign w_hit     = (w_cnt_nxt == r_target);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; abort overrides everything outside IDLE.
  always_comb begin
    w_next = r_state;
    if (abort && (r_state != S_IDLE)) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:      if (w_accept) w_next = S_TURN;
        S_TURN:      if (w_settled) w_next = (r_target != 3'd0) ? S_RAMP_UP : S_DONE;
        S_RAMP_UP: begin
          if (w_hit)         w_next = S_RAMP_DOWN;
          else if (w_at_max) w_next = S_CRUISE;
        end
        S_CRUISE:    if (w_hit) w_next = S_RAMP_DOWN;
        S_RAMP_DOWN: if (w_at_zero) w_next = S_DONE;
        S_DONE:      w_next = S_IDLE;
        default:     w_next = S_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so the registered outputs track it.
  always_comb begin
    w_cmd_rdy = (w_next == S_IDLE);
    w_moving  = (w_next != S_IDLE);
    w_done    = (w_next == S_DONE);
  end

  // Registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_rdy <= 1'b1;
      r_moving  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_cmd_rdy <= w_cmd_rdy;
      r_moving  <= w_moving;
      r_done    <= w_done;
    end
  end

  // Command latch, settle counter and square counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hdng    <= '0;
      r_target  <= '0;
      r_sqr_cnt <= '0;
      r_settle  <= '0;
    end else if (w_accept) begin
      r_hdng    <= cmd_hdng;
      r_target  <= cmd_sqrs;
      r_sqr_cnt <= '0;
      r_settle  <= '0;
    end else begin
      if (r_state == S_TURN) r_settle <= at_hdng ? (r_settle + SW'(1)) : '0;
      if ((r_state == S_RAMP_UP) || (r_state == S_CRUISE)) r_sqr_cnt <= w_cnt_nxt;
    end
  end

  spd_ramp #(
    .MAX_SPD  (MAX_SPD),
    .ACCEL    (ACCEL),
    .DECEL    (DECEL),
    .RAMP_DIV (RAMP_DIV)
  ) u_ramp (
    .clk     (clk),
    .rst     (rst),
    .up      (r_state == S_RAMP_UP),
    .down    (r_state == S_RAMP_DOWN),
    .clr     (w_next == S_IDLE),
    .spd     (frwrd_spd),
    .at_max  (w_at_max),
    .at_zero (w_at_zero)
  );

  assign cmd_rdy   = r_cmd_rdy;
  assign moving    = r_moving;
  assign done      = r_done;
  assign dsrd_hdng = r_hdng;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Scenario bench for cmd_sequencer with a timeline-level reference model.
module tb_cmd_sequencer;

  localparam int MAXS = 672;
  localparam int ACC  = 16;
  localparam int DEC  = 32;
  localparam int RD   = 8;
  localparam int ST   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_vld;
  logic signed [11:0] cmd_hdng;
  logic        [2:0]  cmd_sqrs;
  logic               cmd_rdy;
  logic               at_hdng;
  logic               sqr_pulse;
  logic               abort;
  logic signed [11:0] dsrd_hdng;
  logic               moving;
  logic        [10:0] frwrd_spd;
  logic               done;

  int total = 0;
  int bad   = 0;

  cmd_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_vld   (cmd_vld),
    .cmd_hdng  (cmd_hdng),
    .cmd_sqrs  (cmd_sqrs),
    .cmd_rdy   (cmd_rdy),
    .at_hdng   (at_hdng),
    .sqr_pulse (sqr_pulse),
    .abort     (abort),
    .dsrd_hdng (dsrd_hdng),
    .moving    (moving),
    .frwrd_spd (frwrd_spd),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Speed k edges after entering the up-ramp.
  function automatic int up_spd(input int k);
    int v;
    v = (k / RD) * ACC;
    if (v > MAXS) v = MAXS;
    return v;
  endfunction

  // Speed k edges after entering the down-ramp from s0.
  function automatic int dn_spd(input int s0, input int k);
    int v;
    v = s0 - (k / RD) * DEC;
    if (v < 0) v = 0;
    return v;
  endfunction

  task automatic accept(input logic signed [11:0] h, input logic [2:0] s);
    int n;
    n = 0;
    while (cmd_rdy !== 1'b1 && n < 50) begin
      step;
      n++;
    end
    total++;
    if (cmd_rdy !== 1'b1) begin
      bad++;
      $display("FAIL accept_wait cmd_rdy=%0b want=1 after %0d cycles", cmd_rdy, n);
    end
    cmd_hdng = h;
    cmd_sqrs = s;
    cmd_vld  = 1'b1;
    step;
    cmd_vld  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step;
    step;
    total++;
    if ({cmd_rdy, moving, done} !== 3'b100) begin
      bad++;
      $display("FAIL reset_flags rdy/mov/done=%b want=100", {cmd_rdy, moving, done});
    end
    total++;
    if (frwrd_spd !== 11'd0 || dsrd_hdng !== 12'sd0) begin
      bad++;
      $display("FAIL reset_data spd=%0d hdng=%0d want 0/0", frwrd_spd, dsrd_hdng);
    end
    rst = 1'b0;
    step;
  endtask

  task automatic test_turn_only;
    at_hdng = 1'b1;
    accept(12'h3FF, 3'd0);
    total++;
    if (dsrd_hdng !== 12'h3FF || moving !== 1'b1 || cmd_rdy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL turn_accept hdng=%h mov=%b rdy=%b done=%b want 3ff/1/0/0",
               dsrd_hdng, moving, cmd_rdy, done);
    end
    for (int t = 1; t <= ST + 1; t++) begin
      step;
      total++;
      if (done !== (t == ST) || moving !== (t <= ST) || cmd_rdy !== (t > ST) || frwrd_spd !== 11'd0) begin
        bad++;
        $display("FAIL turn_only t=%0d done=%b mov=%b rdy=%b spd=%0d want %b/%b/%b/0",
                 t, done, moving, cmd_rdy, frwrd_spd, (t == ST), (t <= ST), (t > ST));
      end
    end
    at_hdng = 1'b0;
  endtask

  task automatic test_ramp_up;
    at_hdng   = 1'b1;
    sqr_pulse = 1'b0;
    accept(12'sh123, 3'd2);
    for (int t = 1; t <= ST; t++) begin
      step;
      total++;
      if (frwrd_spd !== 11'd0) begin
        bad++;
        $display("FAIL ramp_turn_spd t=%0d got=%0d want=0", t, frwrd_spd);
      end
    end
    for (int k = 1; k <= 345; k++) begin
      step;
      total++;
      if (frwrd_spd !== 11'(up_spd(k))) begin
        bad++;
        $display("FAIL ramp_up_spd k=%0d got=%0d want=%0d", k, frwrd_spd, up_spd(k));
      end
    end
    total++;
    if (moving !== 1'b1 || done !== 1'b0 || cmd_rdy !== 1'b0) begin
      bad++;
      $display("FAIL cruise_flags mov=%b done=%b rdy=%b want 1/0/0", moving, done, cmd_rdy);
    end
  endtask

  task automatic test_ignore_cmd;
    logic signed [11:0] held;
    held = dsrd_hdng;
    sqr_pulse = 1'b1;
    step;
    sqr_pulse = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step;
      total++;
      if (frwrd_spd !== 11'(MAXS)) begin
        bad++;
        $display("FAIL cruise_after_one_pulse i=%0d got=%0d want=%0d", i, frwrd_spd, MAXS);
      end
    end
    cmd_hdng = held ^ 12'sh5A5;
    cmd_sqrs = 3'd7;
    cmd_vld  = 1'b1;
    step;
    cmd_vld  = 1'b0;
    total++;
    if (dsrd_hdng !== held || cmd_rdy !== 1'b0 || moving !== 1'b1) begin
      bad++;
      $display("FAIL ignore_cmd hdng=%h rdy=%b mov=%b want %h/0/1", dsrd_hdng, cmd_rdy, moving, held);
    end
  endtask

  task automatic test_ramp_down;
    int dcount;
    dcount = 0;
    sqr_pulse = 1'b1;
    step;
    sqr_pulse = 1'b0;
    for (int k = 1; k <= 172; k++) begin
      step;
      if (done === 1'b1) dcount++;
      total++;
      if (frwrd_spd !== 11'(dn_spd(MAXS, k))) begin
        bad++;
        $display("FAIL ramp_down_spd k=%0d got=%0d want=%0d", k, frwrd_spd, dn_spd(MAXS, k));
      end
      total++;
      if (done !== (k == 169)) begin
        bad++;
        $display("FAIL ramp_down_done k=%0d got=%b want=%b", k, done, (k == 169));
      end
      if (k >= 169) begin
        total++;
        if (cmd_rdy !== (k >= 170)) begin
          bad++;
          $display("FAIL ramp_down_rdy k=%0d got=%b want=%b", k, cmd_rdy, (k >= 170));
        end
      end
    end
    total++;
    if (dcount != 1) begin
      bad++;
      $display("FAIL done_pulse_count got=%0d want=1", dcount);
    end
  endtask

  task automatic test_settle_toggle;
    logic [15:0] pat;
    int len, run, ex;
    for (int trial = 0; trial < 4; trial++) begin
      if (trial == 0) begin
        pat = 16'h00F7;
        len = 8;
      end else begin
        len = $urandom_range(ST, 12);
        pat = 16'($urandom);
        for (int i = len - ST; i < 16; i++) pat[i] = 1'b1;
      end
      run = 0;
      ex  = -1;
      for (int i = 0; i < len; i++) begin
        run = pat[i] ? run + 1 : 0;
        if (run == ST && ex < 0) ex = i;
      end
      at_hdng = 1'b0;
      accept(12'($urandom), 3'd0);
      for (int i = 0; i <= ex + 1; i++) begin
        at_hdng = pat[i];
        step;
        total++;
        if (done !== (i == ex)) begin
          bad++;
          $display("FAIL settle trial=%0d i=%0d done=%b want=%b", trial, i, done, (i == ex));
        end
      end
      at_hdng = 1'b0;
      total++;
      if (cmd_rdy !== 1'b1) begin
        bad++;
        $display("FAIL settle_rdy trial=%0d got=%b want=1", trial, cmd_rdy);
      end
    end
  endtask

  task automatic test_abort_ramp;
    logic signed [11:0] h;
    int dseen;
    h = 12'($urandom);
    dseen = 0;
    at_hdng = 1'b1;
    accept(h, 3'($urandom_range(1, 7)));
    for (int t = 0; t < ST + 24; t++) step;
    total++;
    if (frwrd_spd !== 11'd48) begin
      bad++;
      $display("FAIL abort_pre_spd got=%0d want=48", frwrd_spd);
    end
    abort = 1'b1;
    step;
    abort = 1'b0;
    total++;
    if (frwrd_spd !== 11'd0 || moving !== 1'b0 || cmd_rdy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_ramp spd=%0d mov=%b rdy=%b done=%b want 0/0/1/0", frwrd_spd, moving, cmd_rdy, done);
    end
    for (int i = 0; i < 5; i++) begin
      step;
      if (done !== 1'b0 || frwrd_spd !== 11'd0) dseen++;
    end
    total++;
    if (dseen != 0 || dsrd_hdng !== h) begin
      bad++;
      $display("FAIL abort_after bad_cycles=%0d hdng=%h want 0/%h", dseen, dsrd_hdng, h);
    end
    at_hdng = 1'b0;
  endtask

  task automatic test_abort_idle;
    logic signed [11:0] h0;
    h0 = dsrd_hdng;
    abort    = 1'b1;
    cmd_hdng = h0 ^ 12'sh0F0;
    cmd_sqrs = 3'd1;
    cmd_vld  = 1'b1;
    step;
    cmd_vld  = 1'b0;
    abort    = 1'b0;
    total++;
    if (moving !== 1'b0 || dsrd_hdng !== h0) begin
      bad++;
      $display("FAIL abort_idle mov=%b hdng=%h want 0/%h", moving, dsrd_hdng, h0);
    end
    step;
    total++;
    if (moving !== 1'b0 || cmd_rdy !== 1'b1) begin
      bad++;
      $display("FAIL abort_idle_after mov=%b rdy=%b want 0/1", moving, cmd_rdy);
    end
  endtask

  task automatic test_random_moves;
    logic signed [11:0] h;
    int s, d, acc, p, s0, z, eoff, k, want;
    int pk[3];
    for (int trial = 0; trial < 5; trial++) begin
      h = 12'($urandom);
      s = $urandom_range(1, 3);
      d = $urandom_range(0, 3);
      acc = 0;
      for (int i = 0; i < 3; i++) pk[i] = -1;
      for (int i = 0; i < s; i++) begin
        acc += $urandom_range(1, 150);
        pk[i] = acc;
      end
      p    = pk[s - 1];
      s0   = up_spd(p);
      z    = p + ((s0 + DEC - 1) / DEC) * RD;
      eoff = d + ST;
      at_hdng = 1'b0;
      accept(h, 3'(s));
      total++;
      if (dsrd_hdng !== h) begin
        bad++;
        $display("FAIL rnd_hdng trial=%0d got=%h want=%h", trial, dsrd_hdng, h);
      end
      for (int t = 1; t <= eoff + z + 2; t++) begin
        k = t - eoff;
        at_hdng   = (t > d);
        sqr_pulse = (k >= 1) && (k == pk[0] || k == pk[1] || k == pk[2]);
        step;
        sqr_pulse = 1'b0;
        if (k <= 0)      want = 0;
        else if (k <= p) want = up_spd(k);
        else             want = dn_spd(s0, k - p);
        total++;
        if (frwrd_spd !== 11'(want)) begin
          bad++;
          $display("FAIL rnd_spd trial=%0d k=%0d got=%0d want=%0d", trial, k, frwrd_spd, want);
        end
        total++;
        if (done !== (k == z + 1) || moving !== (k <= z + 1) || cmd_rdy !== (k >= z + 2)) begin
          bad++;
          $display("FAIL rnd_flags trial=%0d k=%0d done/mov/rdy=%b%b%b want %b%b%b", trial, k,
                   done, moving, cmd_rdy, (k == z + 1), (k <= z + 1), (k >= z + 2));
        end
      end
      at_hdng = 1'b0;
    end
  endtask

  task automatic test_mid_reset;
    at_hdng = 1'b1;
    accept(12'sh7A1, 3'd3);
    for (int t = 0; t < ST + 20; t++) step;
    total++;
    if (frwrd_spd !== 11'd32) begin
      bad++;
      $display("FAIL mid_reset_pre spd=%0d want=32", frwrd_spd);
    end
    rst = 1'b1;
    step;
    total++;
    if ({cmd_rdy, moving, done} !== 3'b100 || frwrd_spd !== 11'd0 || dsrd_hdng !== 12'sd0) begin
      bad++;
      $display("FAIL mid_reset rdy/mov/done=%b spd=%0d hdng=%h want 100/0/000",
               {cmd_rdy, moving, done}, frwrd_spd, dsrd_hdng);
    end
    rst = 1'b0;
    at_hdng = 1'b0;
    step;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_vld   = 1'b0;
    cmd_hdng  = '0;
    cmd_sqrs  = '0;
    at_hdng   = 1'b0;
    sqr_pulse = 1'b0;
    abort     = 1'b0;
    test_reset;
    test_turn_only;
    test_ramp_up;
    test_ignore_cmd;
    test_ramp_down;
    test_settle_toggle;
    test_abort_ramp;
    test_abort_idle;
    test_random_moves;
    test_mid_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
